// File: rtl/demux1x64_capture.sv
// Registered 1:64 demultiplexer feeding a 64-bit capture bank, with auto-scan frame handoff.
// Optional DEMUX_PARITY_EN adds a frame_parity output registered on entry to FULL.

module demux1x64_group #(
  parameter logic CLR_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       we,
  input  logic [2:0] bidx,
  input  logic       din,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clr)  q       <= {8{CLR_VAL}};
    else if (we)     q[bidx] <= din;
  end
endmodule

module demux1x64_capture #(
  parameter int   N_OUT   = 64,
  parameter int   SEL_W   = 6,
  parameter logic CLR_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             auto,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] out,
  output logic             frame_valid,
  input  logic             frame_ack
`ifdef DEMUX_PARITY_EN
  , output logic           frame_parity
`endif
);
  typedef enum logic [1:0] {FILL, DRAIN, FULL} state_t;

  typedef struct packed {
    logic       din;
    logic [7:0] grp;
    logic [2:0] bidx;
  } s1_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, idx;
  logic             acc, s1_vld;
  s1_t              s1;
  logic [7:0][7:0]  bank;

  // clr squashes a same-cycle acceptance so nothing lands after the clear
  assign acc = in_valid & in_ready & ~clr;
  assign idx = auto ? ptr : sel;
  assign out = bank;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state  <= FILL;
      ptr    <= '0;
      s1_vld <= 1'b0;
      s1     <= '0;
    end else begin
      state  <= state_nxt;
      s1_vld <= acc;
      if (acc) s1 <= '{din: in_bit, grp: 8'b1 << idx[5:3], bidx: idx[2:0]};
      if (acc && auto) ptr <= ptr + 6'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = (state == FILL) & ~rst;
    frame_valid = (state == FULL);
    case (state)
      FILL:    if (acc && auto && ptr == 6'd63) state_nxt = DRAIN;
      DRAIN:   state_nxt = FULL;
      FULL:    if (frame_ack) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  for (genvar g = 0; g < 8; g++) begin : g_grp
    demux1x64_group #(.CLR_VAL(CLR_VAL)) u_grp (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .we  (s1_vld & s1.grp[g]),
      .bidx(s1.bidx),
      .din (s1.din),
      .q   (bank[g])
    );
  end

`ifdef DEMUX_PARITY_EN
  // In DRAIN the pending stage-1 write is always bit 63, so fold it in directly
  always_ff @(posedge clk) begin
    if (rst || clr)          frame_parity <= 1'b0;
    else if (state == DRAIN) frame_parity <= ^{bank[7][6:0], bank[6:0], s1.din};
  end
`endif
endmodule

// File: tb/tb_demux1x64_capture.sv
// Directed bench for demux1x64_capture: manual-write table plus auto-frame, clr and reset sequences.

module tb_demux1x64_capture;
  logic        clk = 0, rst = 1, clr = 0, auto = 0, in_valid = 0, in_bit = 0, frame_ack = 0;
  logic [5:0]  sel = '0;
  logic        in_ready, frame_valid;
  logic [63:0] out;
`ifdef DEMUX_PARITY_EN
  logic        frame_parity;
`endif

  int errors = 0, checks = 0;

  demux1x64_capture dut (
    .clk(clk), .rst(rst), .clr(clr), .auto(auto), .in_valid(in_valid),
    .in_ready(in_ready), .in_bit(in_bit), .sel(sel), .out(out),
    .frame_valid(frame_valid), .frame_ack(frame_ack)
`ifdef DEMUX_PARITY_EN
    , .frame_parity(frame_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic stream(input logic [63:0] data);
    auto = 1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1; in_bit = data[i];
      tick();
    end
    in_valid = 0;
  endtask

  typedef struct {
    logic [5:0]  sel;
    logic        b;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [63:0] prev;
    tbl[0] = '{6'd37, 1'b1, 64'h0000_0020_0000_0000};
    tbl[1] = '{6'd0,  1'b1, 64'h0000_0020_0000_0001};
    tbl[2] = '{6'd63, 1'b1, 64'h8000_0020_0000_0001};
    tbl[3] = '{6'd37, 1'b0, 64'h8000_0000_0000_0001};
    tbl[4] = '{6'd12, 1'b1, 64'h8000_0000_0000_1001};
    tbl[5] = '{6'd63, 1'b0, 64'h0000_0000_0000_1001};
    tbl[6] = '{6'd40, 1'b1, 64'h0000_0100_0000_1001};

    // reset
    #1;
    tick(); tick();
    chk("rst_out", out, 64'h0);
    chk("rst_fv", {63'b0, frame_valid}, 64'h0);
    chk("rst_rdy", {63'b0, in_ready}, 64'h0);
    rst = 0; #1;
    chk("post_rst_rdy", {63'b0, in_ready}, 64'h1);

    // manual writes: unchanged after one edge, updated after two
    prev = 64'h0;
    for (int i = 0; i < 7; i++) begin
      auto = 0; in_valid = 1; sel = tbl[i].sel; in_bit = tbl[i].b;
      tick();
      in_valid = 0; sel = 6'd9; in_bit = 1;
      chk($sformatf("man%0d_lat", i), out, prev);
      tick();
      chk($sformatf("man%0d", i), out, tbl[i].exp);
      prev = tbl[i].exp;
    end
    chk("man_fv", {63'b0, frame_valid}, 64'h0);

    // back-to-back same index: last write wins
    in_valid = 1; sel = 6'd5; in_bit = 1; tick();
    in_bit = 0; tick();
    in_valid = 0;
    chk("b2b_first", out, 64'h0000_0100_0000_1021);
    tick();
    chk("b2b_last", out, 64'h0000_0100_0000_1001);

    // auto frame
    stream(64'hDEAD_BEEF_0123_4567);
    chk("drain_rdy", {63'b0, in_ready}, 64'h0);
    chk("drain_fv", {63'b0, frame_valid}, 64'h0);
    tick();
    chk("full_fv", {63'b0, frame_valid}, 64'h1);
    chk("full_out", out, 64'hDEAD_BEEF_0123_4567);
`ifdef DEMUX_PARITY_EN
    chk("par_dead", {63'b0, frame_parity}, 64'h0);
`endif

    // hold FULL with ignored input
    in_valid = 1; in_bit = 0;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 0;
    chk("hold_out", out, 64'hDEAD_BEEF_0123_4567);
    chk("hold_fv", {63'b0, frame_valid}, 64'h1);
    frame_ack = 1; tick(); frame_ack = 0;
    chk("ack_rdy", {63'b0, in_ready}, 64'h1);
    chk("ack_fv", {63'b0, frame_valid}, 64'h0);
    in_valid = 1; in_bit = 0; tick(); in_valid = 0; tick();
    chk("refill_bit0", out, 64'hDEAD_BEEF_0123_4566);

    // clr with a concurrent write to sel=3
    auto = 0; clr = 1; in_valid = 1; sel = 6'd3; in_bit = 1; #1;
    chk("clr_rdy", {63'b0, in_ready}, 64'h1);
    tick();
    clr = 0; in_valid = 0;
    chk("clr_out", out, 64'h0);
    tick();
    chk("clr_flush", out, 64'h0);

    // reset mid-frame at bit 30, then full refill
    auto = 1;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1; in_bit = 1; tick();
    end
    rst = 1; tick(); rst = 0; in_valid = 0;
    chk("midrst_out", out, 64'h0);
    chk("midrst_fv", {63'b0, frame_valid}, 64'h0);
    stream(64'h0123_4567_89AB_CDEF);
    tick();
    chk("refill_fv", {63'b0, frame_valid}, 64'h1);
    chk("refill_out", out, 64'h0123_4567_89AB_CDEF);
    frame_ack = 1; tick(); frame_ack = 0;

`ifdef DEMUX_PARITY_EN
    stream({64{1'b1}}); tick();
    chk("par_ones", {63'b0, frame_parity}, 64'h0);
    frame_ack = 1; tick(); frame_ack = 0;
    stream(64'h1); tick();
    chk("par_one", {63'b0, frame_parity}, 64'h1);
    chk("par_one_out", out, 64'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
